cmp_pipe: RTL and testbench
===========================

# cmp_pipe

Parametrised, pipelined RV32I branch/set-less-than comparator. Compares two WIDTH-bit operands MSB-first, CHUNK bits per pipeline stage, under a branch_funct3_t opcode. Carries a tag alongside each operation, supports valid/ready backpressure and a synchronous flush. Sits between the register-read stage and branch resolution in the pipelined datapath, replacing the single-cycle combinational comparator.

## Interface
- WIDTH, 32: operand width in bits.
- CHUNK, 8: bits resolved per stage.
  - WIDTH % CHUNK != 0 is an elaboration error.
  - STAGES = WIDTH/CHUNK (localparam, ≥1).
- TAG_W, 4: width of the opaque tag carried with each operation.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  synchronous kill of every in-flight operation.
- in_valid  in  1  operation presented.
- in_ready  out  1  block can accept this cycle.
- cmpop  in  3  branch_funct3_t (beq, bne, blt, bge, bltu, bgeu).
- a  in  WIDTH  first operand (rs1).
- b  in  WIDTH  second operand (rs2 or immediate).
- tag  in  TAG_W  opaque ID, returned unchanged.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result this cycle.
- br_en  out  1  branch condition for cmpop.
- lt_flag  out  1  a < b (signed for blt/bge, unsigned otherwise).
- eq_flag  out  1  a == b.
- out_tag  out  TAG_W  tag of the result.

## Operation
- Pipeline registers S1..S_STAGES. Each register holds: valid, op, tag, a, b, running eq, running lt. Output ports are driven from S_STAGES.
- Chunk index k=0 is the MSB chunk. S1 loads chunk-0 results on accept; S(k+1) folds in chunk k.
  - eq' = eq & (a_k == b_k)
  - lt' = lt | (eq & a_k < b_k)
  - S1 seeds with eq=1, lt=0.
- Chunk 0 under blt/bge compares as signed CHUNK-bit values. All other chunks, and all chunks under the other ops, compare unsigned.
- br_en by opcode:
  - beq: eq
  - bne: !eq
  - blt, bltu: lt
  - bge, bgeu: !lt
  - funct3 010/011: br_en=0; flags still valid, using unsigned compare.
- Advance rule: stage k loads from stage k-1 when S_k is empty or S_k is advancing. S_STAGES advances when out_valid & out_ready.
- in_ready = !rst & !flush & (!S1.valid | S1 advancing). This is a combinational path from out_ready through the stage chain.
- Accept occurs when in_valid & in_ready.
- A stalled stage holds all of its fields stable.
- Flush clears every valid bit. Flush wins over a simultaneous accept or output handshake.
- Data fields (br_en, flags, out_tag) hold their last values when not valid; only valid bits are cleared by flush.

## Timing
- Reset (rst high at an edge): all valid bits =0. out_valid=0, br_en=0, lt_flag=0, eq_flag=0, out_tag=0. in_ready=0 while rst is high and =1 the cycle after.
- Reset asserted mid-operation discards all in-flight work; nothing is emitted afterwards.
- Latency: accept in cycle 0 gives out_valid in cycle STAGES (cycle 4 for 32/8; cycle 1 when CHUNK=WIDTH).
- Throughput is one op/cycle with out_ready held high.
- Full pipeline with out_ready=0: in_ready=0. When out_ready rises, in_ready rises in the same cycle.
- Bubbles collapse: an empty stage loads even if downstream is stalled.
- Ordering is strictly FIFO; tags are never reordered.

## Test plan
- Reset with rst=1 for 2 cycles: out_valid=0, br_en=0, out_tag=0 during and after reset; in_ready=1 in the first cycle after rst falls.
- Signed vs unsigned, single ops with out_ready=1:
  - a=32'hFFFF_FFFF, b=32'h0000_0001, cmpop=blt, tag=3: br_en=1, lt_flag=1, out_tag=3 in cycle 4.
  - Same operands, cmpop=bltu: br_en=0.
  - a=b=32'h8000_0000, cmpop=bge: br_en=1, eq_flag=1.
- Low-chunk decision: a=32'h1234_5600, b=32'h1234_5601, cmpop=bne: br_en=1, lt_flag=1. Confirms equality propagates across all 4 stages.
- Back-to-back ops: six ops, tags 0..5, one per cycle. Results appear in cycles 4..9 in tag order, and in_ready stays 1 throughout.
- Backpressure:
  - Fill the pipe, then hold out_ready=0 for 5 cycles: in_ready=0 and outputs stay stable.
  - Raise out_ready: one result per cycle, none lost or duplicated.
- Flush and parameter variants:
  - Flush with 3 ops in flight plus in_valid=1 in the same cycle: no out_valid until a new accept, and that op's tag emerges 4 cycles later.
  - Repeat the directed tests with CHUNK=32 (latency 1) and CHUNK=1 (latency 32).

Source files
------------

// File: rtl/cmp_pipe.sv
// -----------------------------------------------------------------------------
// cmp_pipe : pipelined RV32I branch / set-less-than comparator.
//
// Operands are compared MSB chunk first, CHUNK bits per pipeline stage, so a
// WIDTH-bit compare takes STAGES = WIDTH/CHUNK cycles. Each stage carries the
// running equal / less-than state plus the operand bits still to be compared.
// Valid/ready handshake on both sides, synchronous flush, synchronous reset.
//
// Ports
//   clk_i        clock, all state changes on the rising edge
//   rst_i        synchronous active-high reset
//   flush_i      synchronous kill of every in-flight operation
//   in_valid_i   operation presented
//   in_ready_o   block accepts this cycle (combinational from out_ready_i)
//   cmpop_i      branch funct3 (beq, bne, blt, bge, bltu, bgeu)
//   a_i, b_i     operands (rs1, rs2/immediate)
//   tag_i        opaque ID returned unchanged with the result
//   out_valid_o  result available
//   out_ready_i  consumer takes the result this cycle
//   br_en_o      branch condition for the operation's funct3
//   lt_flag_o    a < b (signed for blt/bge, unsigned otherwise)
//   eq_flag_o    a == b
//   out_tag_o    tag of the presented result
// -----------------------------------------------------------------------------

package cmp_pipe_pkg;

   // RV32I branch funct3 encodings; 010/011 are not branches.
   typedef enum logic [2:0] {
      BEQ  = 3'b000,
      BNE  = 3'b001,
      BLT  = 3'b100,
      BGE  = 3'b101,
      BLTU = 3'b110,
      BGEU = 3'b111
   } branch_funct3_t;

endpackage

module cmp_pipe
   import cmp_pipe_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CHUNK = 8,
   parameter int unsigned TAG_W = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [2:0]       cmpop_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [TAG_W-1:0] tag_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic             br_en_o,
   output logic             lt_flag_o,
   output logic             eq_flag_o,
   output logic [TAG_W-1:0] out_tag_o
);

   localparam int unsigned STAGES = WIDTH / CHUNK;

   if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("cmp_pipe: WIDTH must be a multiple of CHUNK");
   end

   logic accept_c;

   // Stage 0 can take a new op when it is empty or draining downstream.
   assign in_ready_o = ~rst_i & ~flush_i & g_stage[0].move_c;
   assign accept_c   = in_valid_i & in_ready_o;

   for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
      // Operand bits not yet consumed when entering this stage.
      localparam int unsigned IW = WIDTH - CHUNK * k;

      logic             src_v;
      logic [2:0]       src_op;
      logic [TAG_W-1:0] src_tag;
      logic [IW-1:0]    src_a;
      logic [IW-1:0]    src_b;
      logic             src_eq;
      logic             src_lt;

      logic [CHUNK-1:0] ca;
      logic [CHUNK-1:0] cb;
      logic             chunk_lt;
      logic             eq_d;
      logic             lt_d;
      logic             move_c;
      logic             load_c;

      logic             v_q;
      logic [TAG_W-1:0] tag_q;
      logic             eq_q;
      logic             lt_q;

      // Source of this stage: the input port for stage 0, else the stage above.
      if (k == 0) begin : g_src
         assign src_v   = accept_c;
         assign src_op  = cmpop_i;
         assign src_tag = tag_i;
         assign src_a   = a_i;
         assign src_b   = b_i;
         assign src_eq  = 1'b1;
         assign src_lt  = 1'b0;
      end else begin : g_src
         assign src_v   = g_stage[k-1].v_q;
         assign src_op  = g_stage[k-1].g_fwd.op_q;
         assign src_tag = g_stage[k-1].tag_q;
         assign src_a   = g_stage[k-1].g_fwd.a_q;
         assign src_b   = g_stage[k-1].g_fwd.b_q;
         assign src_eq  = g_stage[k-1].eq_q;
         assign src_lt  = g_stage[k-1].lt_q;
      end

      assign ca = src_a[IW-1 -: CHUNK];
      assign cb = src_b[IW-1 -: CHUNK];

      // Only the MSB chunk carries the sign, and only for blt/bge.
      if (k == 0) begin : g_cmp
         logic sgn_c;
         assign sgn_c    = (src_op == BLT) | (src_op == BGE);
         assign chunk_lt = sgn_c ? ($signed(ca) < $signed(cb)) : (ca < cb);
      end else begin : g_cmp
         assign chunk_lt = ca < cb;
      end

      assign eq_d = src_eq & (ca == cb);
      assign lt_d = src_lt | (src_eq & chunk_lt);

      // Stage may load when empty or when its contents leave this cycle.
      if (k == int'(STAGES) - 1) begin : g_move
         assign move_c = ~v_q | out_ready_i;
      end else begin : g_move
         assign move_c = ~v_q | g_stage[k+1].move_c;
      end

      // Data fields only change when a valid op actually lands here.
      assign load_c = move_c & src_v & ~flush_i;

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            v_q   <= 1'b0;
            tag_q <= '0;
            eq_q  <= 1'b0;
            lt_q  <= 1'b0;
         end else if (flush_i) begin
            v_q <= 1'b0;
         end else if (move_c) begin
            v_q <= src_v;
            if (src_v) begin
               tag_q <= src_tag;
               eq_q  <= eq_d;
               lt_q  <= lt_d;
            end
         end
      end

      if (k != int'(STAGES) - 1) begin : g_fwd
         // Carry the opcode and the still-unresolved low operand bits.
         logic [2:0]          op_q;
         logic [IW-CHUNK-1:0] a_q;
         logic [IW-CHUNK-1:0] b_q;

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               op_q <= '0;
               a_q  <= '0;
               b_q  <= '0;
            end else if (load_c) begin
               op_q <= src_op;
               a_q  <= src_a[IW-CHUNK-1:0];
               b_q  <= src_b[IW-CHUNK-1:0];
            end
         end
      end else begin : g_out
         logic br_d;
         logic br_q;

         // Branch decision from the fully folded flags.
         always_comb begin
            br_d = 1'b0;
            case (src_op)
               BEQ:        br_d = eq_d;
               BNE:        br_d = ~eq_d;
               BLT, BLTU:  br_d = lt_d;
               BGE, BGEU:  br_d = ~lt_d;
               default:    br_d = 1'b0;
            endcase
         end

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               br_q <= 1'b0;
            end else if (load_c) begin
               br_q <= br_d;
            end
         end

         assign out_valid_o = v_q;
         assign br_en_o     = br_q;
         assign lt_flag_o   = lt_q;
         assign eq_flag_o   = eq_q;
         assign out_tag_o   = tag_q;
      end
   end

endmodule

// File: tb/tb_cmp_pipe.sv
// -----------------------------------------------------------------------------
// tb_cmp_pipe : scoreboard bench for cmp_pipe at CHUNK = 8, 32 and 1.
// Each harness drives its own DUT; a negedge monitor pops expected results
// computed from whole-word arithmetic and compares every output handshake.
// -----------------------------------------------------------------------------
module tb_cmp_pipe;
   import cmp_pipe_pkg::*;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned TAG_W = 4;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic             br;
      logic             lt;
      logic             eq;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 'h%0h expected 'h%0h", nm, act, exp);
      end
   endtask

   // Reference: whole-word compare, signed only for blt/bge.
   function automatic exp_t model(input logic [2:0] op, input logic [WIDTH-1:0] x,
                                  input logic [WIDTH-1:0] y, input logic [TAG_W-1:0] t);
      exp_t e;
      logic sgn;
      sgn   = (op == BLT) || (op == BGE);
      e.tag = t;
      e.eq  = (x == y);
      e.lt  = sgn ? ($signed(x) < $signed(y)) : (x < y);
      case (op)
         BEQ:       e.br = e.eq;
         BNE:       e.br = !e.eq;
         BLT, BLTU: e.br = e.lt;
         BGE, BGEU: e.br = !e.lt;
         default:   e.br = 1'b0;
      endcase
      return e;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_h
      localparam int unsigned CH = (g == 0) ? 8 : ((g == 1) ? 32 : 1);
      localparam int unsigned ST = WIDTH / CH;

      logic             rst, flush, in_valid, in_ready, out_valid, out_ready;
      logic             br_en, lt_flag, eq_flag;
      logic [2:0]       cmpop;
      logic [WIDTH-1:0] a, b;
      logic [TAG_W-1:0] tag, out_tag;
      logic             fin = 1'b0;
      exp_t             q[$];

      cmp_pipe #(.WIDTH(WIDTH), .CHUNK(CH), .TAG_W(TAG_W)) dut (
         .clk_i      (clk),
         .rst_i      (rst),
         .flush_i    (flush),
         .in_valid_i (in_valid),
         .in_ready_o (in_ready),
         .cmpop_i    (cmpop),
         .a_i        (a),
         .b_i        (b),
         .tag_i      (tag),
         .out_valid_o(out_valid),
         .out_ready_i(out_ready),
         .br_en_o    (br_en),
         .lt_flag_o  (lt_flag),
         .eq_flag_o  (eq_flag),
         .out_tag_o  (out_tag)
      );

      task automatic ck(input string nm, input logic [63:0] act, input logic [63:0] exp);
         chk($sformatf("chunk%0d %s", CH, nm), act, exp);
      endtask

      task automatic step();
         @(posedge clk);
         #1;
      endtask

      // Monitor: handshakes resolved at the next rising edge.
      always @(negedge clk) begin
         if (rst || flush) begin
            q.delete();
         end else begin
            if (out_valid && out_ready) begin
               if (q.size() == 0) begin
                  ck("unexpected output", 64'(out_tag), 64'hDEAD);
               end else begin
                  exp_t e;
                  e = q.pop_front();
                  ck("sb tag", 64'(out_tag), 64'(e.tag));
                  ck("sb br",  64'(br_en),   64'(e.br));
                  ck("sb lt",  64'(lt_flag), 64'(e.lt));
                  ck("sb eq",  64'(eq_flag), 64'(e.eq));
               end
            end
            if (in_valid && in_ready) q.push_back(model(cmpop, a, b, tag));
         end
      end

      task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] x,
                           input logic [WIDTH-1:0] y, input logic [TAG_W-1:0] t);
         int n;
         n = 0;
         cmpop = op; a = x; b = y; tag = t; in_valid = 1'b1;
         #1;
         while (!in_ready && n < 200) begin
            step();
            n++;
         end
         if (n >= 200) ck("accept timeout", 64'(n), 64'(0));
         step();
         in_valid = 1'b0;
      endtask

      task automatic single(input logic [2:0] op, input logic [WIDTH-1:0] x,
                            input logic [WIDTH-1:0] y, input logic [TAG_W-1:0] t,
                            input logic ebr, input logic elt, input logic eeq, input string nm);
         int n;
         issue(op, x, y, t);
         n = 1;
         while (!out_valid && n < 100) begin
            step();
            n++;
         end
         ck({nm, " latency"}, 64'(n), 64'(ST));
         ck({nm, " br"},  64'(br_en),   64'(ebr));
         ck({nm, " lt"},  64'(lt_flag), 64'(elt));
         ck({nm, " eq"},  64'(eq_flag), 64'(eeq));
         ck({nm, " tag"}, 64'(out_tag), 64'(t));
         step();
      endtask

      task automatic drain();
         int n;
         n = 0;
         while (q.size() != 0 && n < int'(ST) + 50) begin
            step();
            n++;
         end
         ck("drain leftover", 64'(q.size()), 64'(0));
      endtask

      function automatic logic [WIDTH-1:0] rnd_b(input logic [WIDTH-1:0] x);
         case ($urandom_range(0, 3))
            0:       return x;
            1:       return x ^ (32'd1 << $urandom_range(0, 31));
            default: return $urandom;
         endcase
      endfunction

      initial begin
         logic [TAG_W+3:0] snap;
         logic [WIDTH-1:0] x;
         rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
         cmpop = '0; a = '0; b = '0; tag = '0;

         // Reset
         step();
         ck("rst out_valid", 64'(out_valid), 64'(0));
         ck("rst br_en",     64'(br_en),     64'(0));
         ck("rst out_tag",   64'(out_tag),   64'(0));
         ck("rst in_ready",  64'(in_ready),  64'(0));
         step();
         rst = 1'b0;
         #1;
         ck("post-rst in_ready",  64'(in_ready),  64'(1));
         ck("post-rst out_valid", 64'(out_valid), 64'(0));

         // Directed signed/unsigned and low-chunk decisions
         single(BLT,  32'hFFFF_FFFF, 32'h0000_0001, 4'd3, 1'b1, 1'b1, 1'b0, "blt -1<1");
         single(BLTU, 32'hFFFF_FFFF, 32'h0000_0001, 4'd4, 1'b0, 1'b0, 1'b0, "bltu");
         single(BGE,  32'h8000_0000, 32'h8000_0000, 4'd5, 1'b1, 1'b0, 1'b1, "bge eq");
         single(BNE,  32'h1234_5600, 32'h1234_5601, 4'd6, 1'b1, 1'b1, 1'b0, "bne low");
         single(3'b010, 32'h0000_0001, 32'h8000_0000, 4'd7, 1'b0, 1'b1, 1'b0, "funct3 010");

         // Back-to-back, tags 0..5
         for (int i = 0; i < 6; i++) begin
            #1;
            ck("b2b in_ready", 64'(in_ready), 64'(1));
            x = $urandom;
            issue(3'($urandom_range(0, 7)), x, rnd_b(x), 4'(i));
         end
         drain();

         // Backpressure: fill, stall 5 cycles, release
         out_ready = 1'b0;
         for (int i = 0; i < int'(ST); i++) begin
            x = $urandom;
            issue(3'($urandom_range(0, 7)), x, rnd_b(x), 4'(i + 8));
         end
         #1;
         ck("full in_ready", 64'(in_ready), 64'(0));
         snap = {out_valid, br_en, lt_flag, eq_flag, out_tag};
         for (int i = 0; i < 5; i++) begin
            step();
            ck("stall hold", 64'({out_valid, br_en, lt_flag, eq_flag, out_tag}), 64'(snap));
            ck("stall in_ready", 64'(in_ready), 64'(0));
         end
         out_ready = 1'b1;
         #1;
         ck("release in_ready", 64'(in_ready), 64'(1));
         drain();

         // Flush with ops in flight plus a simultaneous in_valid
         for (int i = 1; i <= 3; i++) begin
            x = $urandom;
            issue(BLTU, x, rnd_b(x), 4'(i));
         end
         cmpop = BEQ; a = '0; b = '0; tag = 4'd9; in_valid = 1'b1; flush = 1'b1;
         #1;
         ck("flush in_ready", 64'(in_ready), 64'(0));
         step();
         in_valid = 1'b0; flush = 1'b0;
         for (int i = 0; i < int'(ST) + 2; i++) begin
            ck("post-flush out_valid", 64'(out_valid), 64'(0));
            step();
         end
         single(BEQ, 32'h0000_0055, 32'h0000_0055, 4'd10, 1'b1, 1'b0, 1'b1, "after flush");

         // Reset mid-operation discards in-flight work
         issue(BNE, 32'h1, 32'h2, 4'd11);
         issue(BNE, 32'h3, 32'h3, 4'd12);
         rst = 1'b1;
         #1;
         ck("mid-rst in_ready", 64'(in_ready), 64'(0));
         step();
         rst = 1'b0;
         for (int i = 0; i < int'(ST) + 2; i++) begin
            ck("post-rst silent", 64'(out_valid), 64'(0));
            step();
         end

         // Random traffic with random backpressure and occasional flush
         for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            cmpop     = 3'($urandom_range(0, 7));
            a         = $urandom;
            b         = rnd_b(a);
            tag       = 4'($urandom);
            step();
         end
         flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
         drain();
         fin = 1'b1;
      end
   end

   initial begin
      int n;
      n = 0;
      while (!(g_h[0].fin && g_h[1].fin && g_h[2].fin) && n < 20000) begin
         @(posedge clk);
         n++;
      end
      if (n >= 20000) chk("global timeout", 64'(n), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
